// File: rtl/alu_pkg.sv
// Shared definitions for the sequential RV32 ALU: op codes, default width,
// FSM states and the multi-cycle op classifier.
package alu_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_ADD   = 6'b011001;
  localparam logic [5:0] OP_SUB   = 6'b011011;
  localparam logic [5:0] OP_AND   = 6'b011101;
  localparam logic [5:0] OP_OR    = 6'b011111;
  localparam logic [5:0] OP_XOR   = 6'b100001;
  localparam logic [5:0] OP_SLT   = 6'b100011;
  localparam logic [5:0] OP_SLTU  = 6'b100101;
  localparam logic [5:0] OP_SLL   = 6'b100111;
  localparam logic [5:0] OP_SRL   = 6'b101001;
  localparam logic [5:0] OP_SRA   = 6'b101011;
  localparam logic [5:0] OP_MUL   = 6'b101101;
  localparam logic [5:0] OP_MULHU = 6'b101111;
  localparam logic [5:0] OP_DIV   = 6'b110001;
  localparam logic [5:0] OP_DIVU  = 6'b110011;
  localparam logic [5:0] OP_REM   = 6'b110101;
  localparam logic [5:0] OP_REMU  = 6'b110111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [5:0] op);
    return op inside {OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between operand select and the ALU.
interface alu_seq_if #(
  parameter int unsigned DATA_WIDTH = alu_pkg::DATA_WIDTH
);
  logic                  i_valid;
  logic                  o_ready;
  logic [5:0]            i_alu_op;
  logic [DATA_WIDTH-1:0] i_a;
  logic [DATA_WIDTH-1:0] i_b;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_c;

  modport master (
    output i_valid, i_alu_op, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_c
  );

  modport slave (
    input  i_valid, i_alu_op, i_a, i_b, i_ready,
    output o_ready, o_valid, o_c
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider with sign handling.
// Operands are captured on start; done pulses in the cycle the result is valid.
module alu_muldiv_iter #(
  parameter int unsigned DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);
  import alu_pkg::*;

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                  active_q, special_q, is_mul_q, sel_acc_q, neg_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] acc_q, low_q, opb_q, special_res_q;

  logic                  is_mul, is_signed, is_quot, a_neg, b_neg, div_zero, ovf;
  logic                  sel_acc, neg_res;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    is_mul    = (op == OP_MUL) || (op == OP_MULHU);
    is_signed = (op == OP_DIV) || (op == OP_REM);
    is_quot   = (op == OP_DIV) || (op == OP_DIVU);
    sel_acc   = (op == OP_MULHU) || (op == OP_REM) || (op == OP_REMU);
    a_neg     = is_signed && a[DATA_WIDTH-1];
    b_neg     = is_signed && b[DATA_WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    div_zero  = (b == '0);
    ovf       = is_signed && (a == MIN) && (b == '1);
    // Quotient sign follows operand signs; remainder sign follows the dividend.
    neg_res   = is_quot ? (a_neg ^ b_neg) : a_neg;
  end

  // acc holds the product high half / partial remainder, low the multiplier / quotient.
  logic [DATA_WIDTH:0]   sum, shifted, diff;
  logic [DATA_WIDTH-1:0] acc_n, low_n, base;

  always_comb begin
    sum     = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : '0);
    shifted = {acc_q, low_q[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    if (is_mul_q) begin
      acc_n = sum[DATA_WIDTH:1];
      low_n = {sum[0], low_q[DATA_WIDTH-1:1]};
    end else if (!diff[DATA_WIDTH]) begin
      acc_n = diff[DATA_WIDTH-1:0];
      low_n = {low_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      acc_n = shifted[DATA_WIDTH-1:0];
      low_n = {low_q[DATA_WIDTH-2:0], 1'b0};
    end
    base   = sel_acc_q ? acc_n : low_n;
    result = special_q ? special_res_q : (neg_q ? -base : base);
    done   = active_q && (special_q || (cnt_q == CW'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q      <= 1'b0;
      special_q     <= 1'b0;
      is_mul_q      <= 1'b0;
      sel_acc_q     <= 1'b0;
      neg_q         <= 1'b0;
      cnt_q         <= '0;
      acc_q         <= '0;
      low_q         <= '0;
      opb_q         <= '0;
      special_res_q <= '0;
    end else if (start) begin
      active_q      <= 1'b1;
      cnt_q         <= CW'(DATA_WIDTH);
      acc_q         <= '0;
      low_q         <= is_mul ? a : a_mag;
      opb_q         <= is_mul ? b : b_mag;
      is_mul_q      <= is_mul;
      sel_acc_q     <= sel_acc;
      neg_q         <= !is_mul && neg_res;
      special_q     <= !is_mul && (div_zero || ovf);
      special_res_q <= div_zero ? (is_quot ? '1 : a) : (is_quot ? MIN : '0);
    end else if (active_q) begin
      acc_q <= acc_n;
      low_q <= low_n;
      if (done) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered RV32 ALU: single-cycle ops resolve in one cycle, mul/div run
// iteratively; results are held under valid/ready backpressure.
module alu_seq #(
  parameter int unsigned DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic     i_clk,
  input  logic     i_rst,
  alu_seq_if.slave bus
);
  import alu_pkg::*;

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] c_q, c_d, alu_res, md_result;
  logic [SHW-1:0]        shamt;
  logic                  accept, md_start, md_done;

  assign shamt  = bus.i_b[SHW-1:0];
  assign accept = bus.i_valid && (state_q == ST_IDLE);

  always_comb begin
    alu_res = '0;
    case (bus.i_alu_op)
      OP_NOP:  alu_res = ~bus.i_a;
      OP_ADD:  alu_res = bus.i_a + bus.i_b;
      OP_SUB:  alu_res = bus.i_a - bus.i_b;
      OP_AND:  alu_res = bus.i_a & bus.i_b;
      OP_OR:   alu_res = bus.i_a | bus.i_b;
      OP_XOR:  alu_res = bus.i_a ^ bus.i_b;
      OP_SLT:  alu_res = DATA_WIDTH'($signed(bus.i_a) < $signed(bus.i_b));
      OP_SLTU: alu_res = DATA_WIDTH'(bus.i_a < bus.i_b);
      OP_SLL:  alu_res = bus.i_a << shamt;
      OP_SRL:  alu_res = bus.i_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.i_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  alu_muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
    .clk    (i_clk),
    .rst    (i_rst),
    .start  (md_start),
    .op     (bus.i_alu_op),
    .a      (bus.i_a),
    .b      (bus.i_b),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    md_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_multicycle(bus.i_alu_op)) begin
            md_start = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            c_d     = alu_res;
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          c_d     = md_result;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
    end
  end

  assign bus.o_ready = (state_q == ST_IDLE);
  assign bus.o_valid = (state_q == ST_DONE);
  assign bus.o_c     = c_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake/reset
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.DATA_WIDTH(DW)) bus();

  alu_seq #(.DATA_WIDTH(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int unsigned lat;
    int unsigned hold;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned ua, ub;
    int sa, sb;
    bit ovf;
    ua  = 64'(a);
    ub  = 64'(b);
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_NOP:   return ~a;
      OP_ADD:   return 32'(ua + ub);
      OP_SUB:   return 32'(ua - ub);
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:  return (ua < ub) ? 32'd1 : 32'd0;
      OP_SLL:   return a << (b % 32);
      OP_SRL:   return a >> (b % 32);
      OP_SRA:   return 32'(sa >>> (b % 32));
      OP_MUL:   return 32'(ua * ub);
      OP_MULHU: return 32'((ua * ub) >> 32);
      OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      OP_REMU:  return (b == 0) ? a : 32'(ua % ub);
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      OP_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(sa % sb);
      end
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int unsigned model_lat(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    bit is_div, is_sdiv;
    is_div  = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_sdiv = op inside {OP_DIV, OP_REM};
    if (!(is_div || op == OP_MUL || op == OP_MULHU)) return 1;
    if (is_div && b == 0) return 2;
    if (is_sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return DW + 1;
  endfunction

  task automatic add_vec(input string name, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int unsigned lat, input int unsigned hold);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.hold = hold;
    vecs.push_back(v);
  endtask

  // Latency = rising edges from driving the request until o_valid is seen.
  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int unsigned lat, input int unsigned hold);
    int unsigned cyc;
    @(negedge clk);
    check({name, " ready_before"}, 32'(bus.o_ready), 32'd1);
    bus.i_valid  = 1'b1;
    bus.i_alu_op = op;
    bus.i_a      = a;
    bus.i_b      = b;
    bus.i_ready  = 1'b0;
    cyc = 0;
    while (cyc == 0 || (!bus.o_valid && cyc < 100)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        bus.i_valid  = 1'b0;
        bus.i_a      = $urandom;
        bus.i_b      = $urandom;
        bus.i_alu_op = 6'($urandom);
      end
    end
    if (!bus.o_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: o_valid=0 after %0d cycles, required within 100", name, cyc);
    end else begin
      check({name, " latency"}, 32'(cyc), 32'(lat));
    end
    check({name, " result"}, bus.o_c, exp);
    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({name, " held_c"}, bus.o_c, exp);
      check({name, " held_valid"}, 32'(bus.o_valid), 32'd1);
      check({name, " held_ready"}, 32'(bus.o_ready), 32'd0);
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    check({name, " valid_after_take"}, 32'(bus.o_valid), 32'd0);
    check({name, " ready_after_take"}, 32'(bus.o_ready), 32'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] ops [19];

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rop;
    int unsigned seen_valid;

    rst          = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b0;
    bus.i_alu_op = '0;
    bus.i_a      = '0;
    bus.i_b      = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(bus.o_ready), 32'd1);
    check("reset valid", 32'(bus.o_valid), 32'd0);
    check("reset c", bus.o_c, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    add_vec("add",        OP_ADD,   32'd5,         32'd7,         32'd12,        1,  0);
    add_vec("sub",        OP_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE, 1,  0);
    add_vec("sltu",       OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,         1,  0);
    add_vec("slt",        OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         1,  0);
    add_vec("sra",        OP_SRA,   32'hFFFF_FFFF, 32'h24,        32'hFFFF_FFFF, 1,  0);
    add_vec("srl",        OP_SRL,   32'hFFFF_FFFF, 32'd4,         32'h0FFF_FFFF, 1,  0);
    add_vec("sll",        OP_SLL,   32'd1,         32'd31,        32'h8000_0000, 1,  0);
    add_vec("nop",        OP_NOP,   32'h0F0F_0F0F, 32'd0,         32'hF0F0_F0F0, 1,  0);
    add_vec("xor",        OP_XOR,   32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1,  0);
    add_vec("unlisted",   6'b000001, 32'd5,        32'd7,         32'd0,         1,  0);
    add_vec("add_hold3",  OP_ADD,   32'd100,       32'd23,        32'd123,       1,  3);
    add_vec("divu",       OP_DIVU,  32'd100,       32'd7,         32'd14,        33, 0);
    add_vec("remu",       OP_REMU,  32'd100,       32'd7,         32'd2,         33, 0);
    add_vec("div_neg",    OP_DIV,   32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 33, 0);
    add_vec("rem_neg",    OP_REM,   32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33, 0);
    add_vec("div_zero",   OP_DIV,   32'd5,         32'd0,         32'hFFFF_FFFF, 2,  0);
    add_vec("rem_zero",   OP_REM,   32'd5,         32'd0,         32'd5,         2,  0);
    add_vec("divu_zero",  OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 2,  0);
    add_vec("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  0);
    add_vec("rem_ovf",    OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2,  0);
    add_vec("divu_big",   OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 0);
    add_vec("mul",        OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         33, 3);
    add_vec("mulhu",      OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
             vecs[i].hold);

    // Reset in the middle of a divide discards the partial result.
    run_op("add_pre_rst", OP_ADD, 32'd5, 32'd7, 32'd12, 1, 0);
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_alu_op = OP_DIVU;
    bus.i_a      = 32'd100;
    bus.i_b      = 32'd7;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy valid", 32'(bus.o_valid), 32'd0);
    check("rst_busy c", bus.o_c, 32'd0);
    check("rst_busy ready", 32'(bus.o_ready), 32'd1);
    seen_valid = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) seen_valid++;
    end
    check("rst_busy no_late_valid", 32'(seen_valid), 32'd0);
    run_op("add_post_rst", OP_ADD, 32'd3, 32'd4, 32'd7, 1, 0);

    ops = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL,
            OP_SRA, OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, 6'b000001, 6'b111111};
    for (int unsigned n = 0; n < 150; n++) begin
      rop = ops[$urandom_range(0, 18)];
      ra  = pick_operand();
      rb  = pick_operand();
      run_op($sformatf("rand%0d_op%02h", n, rop), rop, ra, rb, model_res(rop, ra, rb),
             model_lat(rop, ra, rb), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor of the single-cycle RV32 ALU. It executes all base integer ALU operations with one cycle of latency. It adds iterative multiply/divide (MUL, MULHU, DIV, DIVU, REM, REMU) behind a valid/ready handshake. It sits in the execute stage, between operand select and writeback, and stalls the pipeline through `o_ready`/`o_valid` while a multi-cycle operation runs.

## Interface
- `DATA_WIDTH`, 32: operand and result width. Power of two, minimum 8.
- `i_clk`  in  1: clock; all state changes on rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_valid`  in  1: request strobe; the operation is accepted when `i_valid && o_ready`.
- `o_ready`  out  1: unit idle and able to accept a request.
- `i_alu_op`  in  6: operation code (shared package).
- `i_a`, `i_b`  in  DATA_WIDTH: operands. Sampled only at accept.
- `o_valid`  out  1: result available; held until `i_ready`.
- `i_ready`  in  1: consumer takes the result.
- `o_c`  out  DATA_WIDTH: registered result, stable while `o_valid`.

## Operation
- Existing op codes are unchanged: NOP 000000, ADD 011001, SUB 011011, AND 011101, OR 011111, XOR 100001, SLT 100011, SLTU 100101, SLL 100111, SRL 101001, SRA 101011.
- New op codes: MUL 101101, MULHU 101111, DIV 110001, DIVU 110011, REM 110101, REMU 110111.
- NOP result is `~a`.
- SLT is a signed compare. SLTU is a true unsigned compare. Both produce 0 or 1, zero-extended.
- Shifts use `b[$clog2(DATA_WIDTH)-1:0]` as the amount. SRA sign-fills.
- ADD, SUB and MUL wrap modulo 2^DATA_WIDTH. MULHU returns the upper half of the unsigned 2·DATA_WIDTH product.
- DIV and REM round toward zero, and the remainder takes the sign of the dividend.
- Divide by zero: quotient is all ones; remainder is the dividend.
- Signed overflow (MIN / −1): quotient is MIN; remainder is 0.
- An unlisted op code produces result 0 with single-cycle latency.
- Operands and op code are latched at accept. Input changes afterwards have no effect.
- FSM states:
  - IDLE: `o_ready`=1. On accept of a single-cycle op, go to DONE. On accept of a mul/div op, go to BUSY with the counter loaded to DATA_WIDTH.
  - BUSY: one multiply (shift-add) or divide (restoring) step per cycle. The counter decrements each cycle. When it reaches 0, sign-fix the result, load `o_c`, and go to DONE.
  - DONE: `o_valid`=1. When `i_ready`=1, go to IDLE.
- `o_ready` = (state == IDLE) exactly. There is no accept in DONE or BUSY, and no combinational path from `i_ready` to `o_ready`.
- Signed divide works on magnitudes. The quotient is negated if the operand signs differ; the remainder is negated if the dividend is negative. Zero-divisor and overflow cases bypass the iteration and resolve in one BUSY cycle.

## Timing
- Reset values: state IDLE, `o_ready`=1, `o_valid`=0, `o_c`=0, counter 0.
- Single-cycle op accepted at edge N: `o_valid`=1 and `o_c` correct after edge N+1.
- Mul/div op accepted at edge N: `o_valid` after edge N+1+DATA_WIDTH (33 cycles for 32-bit).
- Divide-by-zero and overflow cases: `o_valid` after edge N+2.
- Result taken at edge M (`o_valid && i_ready`): `o_valid`=0 and `o_ready`=1 after edge M.
- Peak throughput is one single-cycle op per 2 cycles.
- Backpressure: `o_c` and `o_valid` stay constant while `i_ready`=0, for any number of cycles.
- `i_rst` has priority over every transition, in any state including mid-BUSY. The next cycle the unit is in IDLE with `o_valid`=0 and `o_c`=0, and the partial result is discarded.

## Structure
- Package `alu_pkg`: op-code constants, `DATA_WIDTH` default, FSM state enum, and an `is_multicycle(op)` function.
- Combinational single-cycle datapath lives in the top level.
- Sub-module `alu_muldiv_iter`: counter, partial product/remainder registers, and sign handling. It has start/done handshake to the top-level FSM.

## Test plan
- ADD a=5, b=7 accepted at edge N → `o_valid`=1 and `o_c`=12 after edge N+1. SUB 5−7 → 0xFFFFFFFE.
- a=0xFFFFFFFF, b=1: SLTU → 0; SLT → 1; SRA by 0x24 (amount 4) → 0xFFFFFFFF; SRL by 4 → 0x0FFFFFFF.
- DIVU 100/7 → 14 exactly 33 cycles after accept; REMU → 2; DIV −100/7 → 0xFFFFFFF2 (−14); REM → 0xFFFFFFFE (−2).
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0; each after edge N+2.
- MUL 0xFFFFFFFF×0xFFFFFFFF → 1; MULHU → 0xFFFFFFFE. Operands changed during BUSY have no effect on the result.
- Handshake and reset:
  - Hold `i_ready`=0 for 3 cycles after `o_valid` → `o_c` held and `o_ready`=0.
  - Assert `i_rst` at BUSY cycle 10 → IDLE, `o_valid`=0 and `o_c`=0 next cycle; a new ADD then completes normally.
